// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-path frame checker.
// Provides parity-mode encodings, error-bit positions inside the per-frame
// error vector, the output-holding FSM state type and the parity-error helper.
package uart_pkg;

   // Parity-mode encodings carried on parity_type
   localparam logic [1:0] PAR_NONE0 = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_EVEN  = 2'b10;
   localparam logic [1:0] PAR_NONE1 = 2'b11;

   // Bit positions inside out_error
   localparam int ERR_PARITY  = 0;
   localparam int ERR_START   = 1;
   localparam int ERR_STOP    = 2;
   localparam int ERR_OVERRUN = 3;

   // Output-holding register state
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   // Parity error from the XOR of the data bits and the received parity bit.
   // Odd mode needs an odd total number of ones, even mode an even total.
   function automatic logic parity_error(input logic       data_xor,
                                         input logic       parity_bit,
                                         input logic [1:0] parity_type);
      logic res;
      case (parity_type)
         PAR_ODD:              res = ~(data_xor ^ parity_bit);
         PAR_EVEN:             res = data_xor ^ parity_bit;
         PAR_NONE0, PAR_NONE1: res = 1'b0;
         default:              res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/uart_err_eval.sv
// Combinational frame-integrity evaluation for one deserialised UART frame.
// Ports:
//   frame_data  - received data bits (LSB first as received)
//   start_bit   - sampled start bit (must be 0)
//   parity_bit  - sampled parity bit (ignored when parity is off)
//   stop_bits   - [0] first stop, [1] second stop (must be 1)
//   parity_type - 01 odd, 10 even, 00/11 none
//   two_stop    - 1 = second stop bit is also checked
//   err         - {stop_err, start_err, parity_err}
module uart_err_eval
   import uart_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] frame_data,
   input  logic              start_bit,
   input  logic              parity_bit,
   input  logic [1:0]        stop_bits,
   input  logic [1:0]        parity_type,
   input  logic              two_stop,
   output logic [2:0]        err
);

   // Evaluate parity, start and stop violations from this frame's fields only
   always_comb begin
      err             = 3'b000;
      err[ERR_PARITY] = parity_error(^frame_data, parity_bit, parity_type);
      err[ERR_START]  = start_bit;
      err[ERR_STOP]   = ~stop_bits[0] | (two_stop & ~stop_bits[1]);
   end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// Registered frame-integrity checker between the UART Rx deserialiser and its
// consumer. Holds one checked frame on a valid/ready output, flags overruns,
// and keeps sticky error status plus saturating frame/error counters.
// Ports:
//   clock, reset_n            - clock and asynchronous active-low reset
//   frame_valid + fields      - one deserialised frame per single-cycle pulse
//   parity_type, two_stop     - frame format, sampled with frame_valid
//   out_valid/out_ready       - output handshake
//   out_data, out_error       - held data and {overrun, stop, start, parity}
//   status_sticky             - OR of loaded out_error since last clear
//   status_clear              - clears sticky and both counters
//   frame_count, error_count  - saturating statistics
module uart_rx_frame_checker
   import uart_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              frame_valid,
   input  logic [DATA_W-1:0] frame_data,
   input  logic              start_bit,
   input  logic              parity_bit,
   input  logic [1:0]        stop_bits,
   input  logic [1:0]        parity_type,
   input  logic              two_stop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        out_error,
   output logic [3:0]        status_sticky,
   input  logic              status_clear,
   output logic [CNT_W-1:0]  frame_count,
   output logic [CNT_W-1:0]  error_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_e            state_q, state_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [3:0]        out_error_q, out_error_d;
   logic [3:0]        sticky_q, sticky_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic              ovr_pending_q, ovr_pending_d;
   logic              load_s;
   logic [2:0]        err_s;
   logic [CNT_W-1:0]  frame_base_s, err_base_s;
   logic [3:0]        sticky_base_s;

   uart_err_eval #(.DATA_W(DATA_W)) u_err_eval (
      .frame_data  (frame_data),
      .start_bit   (start_bit),
      .parity_bit  (parity_bit),
      .stop_bits   (stop_bits),
      .parity_type (parity_type),
      .two_stop    (two_stop),
      .err         (err_s)
   );

   // Next-state, output-register load and overrun tracking
   always_comb begin
      state_d       = state_q;
      out_data_d    = out_data_q;
      out_error_d   = out_error_q;
      ovr_pending_d = ovr_pending_q;
      load_s        = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (frame_valid) begin
               load_s  = 1'b1;
               state_d = ST_FULL;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (frame_valid) begin
               // A reload only happens when the held frame leaves this cycle;
               // otherwise the newcomer is dropped and remembered as overrun.
               if (out_ready) begin
                  load_s = 1'b1;
               end else begin
                  ovr_pending_d = 1'b1;
               end
               state_d = ST_FULL;
            end else if (out_ready) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_FULL;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      if (load_s) begin
         out_data_d                        = frame_data;
         out_error_d[ERR_STOP:ERR_PARITY]  = err_s;
         out_error_d[ERR_OVERRUN]          = ovr_pending_q;
         ovr_pending_d                     = 1'b0;
      end else begin
         out_data_d = out_data_q;
      end
   end

   // Statistics: a clear and a load in the same cycle leave only that frame
   always_comb begin
      frame_base_s  = status_clear ? {CNT_W{1'b0}} : frame_cnt_q;
      err_base_s    = status_clear ? {CNT_W{1'b0}} : err_cnt_q;
      sticky_base_s = status_clear ? 4'b0000 : sticky_q;
      frame_cnt_d   = frame_base_s;
      err_cnt_d     = err_base_s;
      sticky_d      = sticky_base_s;
      if (load_s) begin
         sticky_d = sticky_base_s | out_error_d;
         if (frame_base_s != CNT_MAX) begin
            frame_cnt_d = frame_base_s + CNT_W'(1);
         end else begin
            frame_cnt_d = frame_base_s;
         end
         if ((|err_s) && (err_base_s != CNT_MAX)) begin
            err_cnt_d = err_base_s + CNT_W'(1);
         end else begin
            err_cnt_d = err_base_s;
         end
      end else begin
         sticky_d = sticky_base_s;
      end
   end

   // State and datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_EMPTY;
         out_data_q    <= {DATA_W{1'b0}};
         out_error_q   <= 4'b0000;
         sticky_q      <= 4'b0000;
         frame_cnt_q   <= {CNT_W{1'b0}};
         err_cnt_q     <= {CNT_W{1'b0}};
         ovr_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_data_q    <= out_data_d;
         out_error_q   <= out_error_d;
         sticky_q      <= sticky_d;
         frame_cnt_q   <= frame_cnt_d;
         err_cnt_q     <= err_cnt_d;
         ovr_pending_q <= ovr_pending_d;
      end
   end

   assign out_valid     = (state_q == ST_FULL);
   assign out_data      = out_data_q;
   assign out_error     = out_error_q;
   assign status_sticky = sticky_q;
   assign frame_count   = frame_cnt_q;
   assign error_count   = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Scoreboard bench for uart_rx_frame_checker (DATA_W=8, CNT_W=2 so that
// counter saturation is reached quickly). The driver computes the expected
// frame/error word from the frame rules and pushes it into a queue; a monitor
// on the falling edge compares whatever the DUT presents against the queue.
module tb_uart_rx_frame_checker;

   localparam int DATA_W  = 8;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clock;
   logic              reset_n;
   logic              frame_valid;
   logic [DATA_W-1:0] frame_data;
   logic              start_bit;
   logic              parity_bit;
   logic [1:0]        stop_bits;
   logic [1:0]        parity_type;
   logic              two_stop;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [3:0]        out_error;
   logic [3:0]        status_sticky;
   logic              status_clear;
   logic [CNT_W-1:0]  frame_count;
   logic [CNT_W-1:0]  error_count;

   uart_rx_frame_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .frame_valid   (frame_valid),
      .frame_data    (frame_data),
      .start_bit     (start_bit),
      .parity_bit    (parity_bit),
      .stop_bits     (stop_bits),
      .parity_type   (parity_type),
      .two_stop      (two_stop),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_error     (out_error),
      .status_sticky (status_sticky),
      .status_clear  (status_clear),
      .frame_count   (frame_count),
      .error_count   (error_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state (what the DUT should hold after the next edge)
   logic [11:0] sb_q[$];       // {out_error, out_data}
   bit          m_held = 1'b0;
   bit          m_ovr  = 1'b0;
   int          m_fc   = 0;
   int          m_ec   = 0;
   logic [3:0]  m_st   = 4'b0000;

   // Expectations for the DUT state currently visible
   bit          exp_valid = 1'b0;
   int          exp_fc    = 0;
   int          exp_ec    = 0;
   logic [3:0]  exp_st    = 4'b0000;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame rules: odd mode wants an odd count of ones over data+parity,
   // even mode an even count; start must be 0; checked stop bits must be 1.
   function automatic logic [2:0] model_err(input logic [7:0] d, input logic sb,
                                            input logic pb, input logic [1:0] sp,
                                            input logic [1:0] pt, input logic ts);
      int  ones;
      bit  p_err;
      bit  s_err;
      ones  = $countones(d) + int'(pb);
      p_err = 1'b0;
      if (pt == 2'b01) p_err = (ones % 2 == 0);
      if (pt == 2'b10) p_err = (ones % 2 == 1);
      s_err = (sp[0] == 1'b0) || (ts && (sp[1] == 1'b0));
      return {s_err, sb, p_err};
   endfunction

   task automatic snapshot();
      exp_valid = m_held;
      exp_fc    = m_fc;
      exp_ec    = m_ec;
      exp_st    = m_st;
   endtask

   // One clock of stimulus plus the model's view of the following edge
   task automatic drive(input logic fv, input logic [7:0] d, input logic sb,
                        input logic pb, input logic [1:0] sp, input logic [1:0] pt,
                        input logic ts, input logic rdy, input logic clr);
      logic [2:0] e;
      @(posedge clock);
      #1;
      snapshot();
      frame_valid  = fv;
      frame_data   = d;
      start_bit    = sb;
      parity_bit   = pb;
      stop_bits    = sp;
      parity_type  = pt;
      two_stop     = ts;
      out_ready    = rdy;
      status_clear = clr;
      if (clr) begin
         m_fc = 0;
         m_ec = 0;
         m_st = 4'b0000;
      end
      if (fv && (!m_held || rdy)) begin
         e = model_err(d, sb, pb, sp, pt, ts);
         sb_q.push_back({m_ovr, e, d});
         m_st   = m_st | {m_ovr, e};
         m_ovr  = 1'b0;
         m_held = 1'b1;
         if (m_fc < CNT_MAX) m_fc++;
         if ((e != 3'b000) && (m_ec < CNT_MAX)) m_ec++;
      end else if (fv) begin
         m_ovr = 1'b1;
      end else if (rdy) begin
         m_held = 1'b0;
      end
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, rdy, 1'b0);
   endtask

   // Monitor: compare presented frame and statistics, pop on handshake
   always @(negedge clock) begin
      if (reset_n) begin
         check("out_valid", int'(out_valid), int'(exp_valid));
         check("frame_count", int'(frame_count), exp_fc);
         check("error_count", int'(error_count), exp_ec);
         check("status_sticky", int'(status_sticky), int'(exp_st));
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_frame", 1, 0);
            end else begin
               check("out_frame", int'({out_error, out_data}), int'(sb_q[0]));
               if (out_ready) void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      reset_n      = 1'b0;
      frame_valid  = 1'b0;
      frame_data   = 8'h00;
      start_bit    = 1'b0;
      parity_bit   = 1'b0;
      stop_bits    = 2'b11;
      parity_type  = 2'b00;
      two_stop     = 1'b0;
      out_ready    = 1'b0;
      status_clear = 1'b0;
      #12;
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_error", int'(out_error), 0);
      reset_n = 1'b1;
      idle(1'b0);

      // 1: odd parity good frame
      drive(1'b1, 8'hA5, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1);
      // 2: even parity, start and second-stop errors
      drive(1'b1, 8'h07, 1'b1, 1'b0, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1);
      // format changes while held must not matter
      drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
      idle(1'b1);

      // 3: overrun while stalled, then reload carries overrun flag
      drive(1'b1, 8'h31, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'h32, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'h33, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      drive(1'b1, 8'h34, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
      idle(1'b1);

      // 4: back-to-back with permanent ready
      drive(1'b1, 8'h11, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 8'h22, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // 5: saturation with bad parity, then clear together with a good frame
      for (int i = 0; i < 5; i++)
         drive(1'b1, 8'(i), 1'b0, ^8'(i), 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      drive(1'b1, 8'h5A, 1'b0, 1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 1'b1);
      idle(1'b1);

      // 6: reset while FULL with an overrun pending
      drive(1'b1, 8'h77, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'h78, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      snapshot();
      frame_valid = 1'b0;
      out_ready   = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_mid_valid", int'(out_valid), 0);
      check("rst_mid_fcount", int'(frame_count), 0);
      check("rst_mid_ecount", int'(error_count), 0);
      check("rst_mid_sticky", int'(status_sticky), 0);
      sb_q.delete();
      m_held = 1'b0;
      m_ovr  = 1'b0;
      m_fc   = 0;
      m_ec   = 0;
      m_st   = 4'b0000;
      snapshot();
      @(posedge clock);
      #3;
      reset_n = 1'b1;
      drive(1'b1, 8'h99, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
      idle(1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 9) == 0),
               1'($urandom), ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11,
               2'($urandom), 1'($urandom), 1'($urandom_range(0, 99) < 60),
               1'($urandom_range(0, 29) == 0));
      end
      for (int i = 0; i < 4; i++) idle(1'b1);
      @(negedge clock);
      check("queue_drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
- Registered, parametrised frame-integrity checker for the UART receive path. It sits between the Rx SIPO/deserialiser and the consumer.
- Accepts one deserialised frame per `frame_valid` pulse and checks start, parity and stop bits for a configurable data width, parity mode and 1 or 2 stop bits.
- Presents the data plus a per-frame error vector on a valid/ready output, with overrun detection.
- Maintains sticky error status and saturating frame/error counters for software.

Parameters:
- DATA_W, 8, data bits per frame; legal values 5..9.
- CNT_W, 16, width of each saturating statistics counter.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_valid  in  1  single-cycle pulse: frame fields below are valid.
- frame_data  in  DATA_W  received data bits, LSB first as received.
- start_bit  in  1  sampled start bit.
- parity_bit  in  1  sampled parity bit; ignored when parity is off.
- stop_bits  in  2  sampled stop bits; [0] = first stop, [1] = second stop.
- parity_type  in  2  parity mode: 01 odd, 10 even, 00/11 none.
- two_stop  in  1  1 = two stop bits are checked.
- out_valid  out  1  output frame available.
- out_ready  in  1  consumer accepts the output frame.
- out_data  out  DATA_W  checked data.
- out_error  out  4  per-frame errors: [0] parity, [1] start, [2] stop, [3] overrun-before-this-frame.
- status_sticky  out  4  OR-accumulated `out_error` bits since the last clear.
- status_clear  in  1  pulse: clears `status_sticky` and both counters.
- frame_count  out  CNT_W  frames accepted into the output register; saturating.
- error_count  out  CNT_W  accepted frames with any of `out_error[2:0]` set; saturating.

Behaviour:
- Reset: `out_valid`=0, `out_data`=0, `out_error`=0, `status_sticky`=0, both counters=0, `ovr_pending`=0, FSM in EMPTY.
- Error evaluation on the `frame_valid` cycle uses the inputs of that cycle only.
  - parity_err, odd mode: (^frame_data ^ parity_bit) == 0.
  - parity_err, even mode: (^frame_data ^ parity_bit) == 1.
  - parity_err, none mode: always 0.
  - start_err = start_bit.
  - stop_err = ~stop_bits[0] | (two_stop & ~stop_bits[1]).
- FSM states:
  - EMPTY:
    - `frame_valid` -> load `out_data`/`out_error`, go to FULL.
    - `out_valid` rises the next cycle; latency is 1 clock.
  - FULL:
    - `out_valid`=1; outputs stable until handshake.
    - `out_ready` & ~`frame_valid` -> EMPTY.
    - `out_ready` & `frame_valid` -> reload the new frame, stay FULL (back-to-back with no bubble).
    - ~`out_ready` & `frame_valid` -> new frame discarded, `ovr_pending` set, outputs unchanged.
- Overrun:
  - The next frame loaded carries `out_error[3]`=1.
  - `ovr_pending` clears on that load.
  - Discarded frames are not counted.
- Statistics update on each load into the output register:
  - `frame_count` += 1.
  - `error_count` += 1 if any of parity/start/stop error is set.
  - `status_sticky` |= loaded `out_error`, including bit 3.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- `status_clear`:
  - Zeroes sticky and counters on the next edge.
  - If a load occurs in the same cycle, the result reflects only that frame: counters = 1 / (0 or 1), sticky = that frame's errors.
- `parity_type` and `two_stop` are sampled only on `frame_valid`; changes mid-hold do not alter a held frame.
- Reset asserted mid-operation: all state returns to reset values immediately; a held frame is lost with no overrun flagged.

Decomposition:
- Shared package `uart_pkg`:
  - Parity encodings PAR_NONE0=00, PAR_ODD=01, PAR_EVEN=10, PAR_NONE1=11.
  - Error-bit indices ERR_PARITY=0, ERR_START=1, ERR_STOP=2, ERR_OVERRUN=3.
  - FSM state encodings.
- One natural sub-module: `uart_err_eval`, purely combinational, DATA_W-parametrised. Inputs are the frame fields; output is the 3-bit error vector. It is reusable by the Tx loopback checker.

Test Plan:
1. DATA_W=8, odd parity, data 8'hA5 (4 ones), parity_bit=1, start=0, stop=01 -> one cycle later `out_valid`=1, `out_data`=A5, `out_error`=0000, `frame_count`=1, `error_count`=0.
2. Even parity, data 8'h07, parity_bit=0, start=1, two_stop=1, stop_bits=01 -> `out_error`=0111, `status_sticky`=0111, `error_count`=1.
3. Hold `out_ready`=0 and send 3 frames -> first frame held unchanged, others dropped; raise `out_ready` and send frame 4 -> frame 4 shows `out_error[3]`=1, `frame_count`=2.
4. `out_ready`=1 permanently, `frame_valid` on consecutive cycles with 0x11, 0x22 -> `out_data` 11 then 22 on consecutive cycles, no bubble, no overrun.
5. CNT_W=2, send 5 bad-parity frames -> both counters stick at 3; `status_clear` together with a good frame -> `frame_count`=1, `error_count`=0, sticky=0000.
6. Assert reset_n low while FULL, mid-cycle -> `out_valid` drops immediately, all counters/sticky 0, and the next frame after release has `out_error[3]`=0.
